// File: rtl/neural_layer_par.sv
// Fully connected float32 layer: OUT_SIZE neurons accumulate IN_SIZE products onto a bias, optional ReLU.
// Define NEURAL_LAYER_DISPLAY_EN to print every result in simulation.
module neural_layer_par #(
    parameter int IN_SIZE  = 10,
    parameter int OUT_SIZE = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [32*IN_SIZE-1:0]        in,
    input  logic [32*IN_SIZE*OUT_SIZE-1:0] weights,
    input  logic [32*OUT_SIZE-1:0]       bias,
    input  logic                         activation,
    output logic [32*OUT_SIZE-1:0]       result,
    output logic                         busy,
    output logic                         done
);

    localparam int DATA_W = 32;
    localparam int K_W    = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

    typedef enum logic [1:0] {IDLE, MAC, ACT} state_t;

    state_t             state, state_nxt;
    logic [K_W-1:0]     k;
    logic               act_q;
    logic               done_q;
    logic [DATA_W-1:0]  acc [OUT_SIZE];
    logic [DATA_W-1:0]  in_k;

    // Flush exponents <= 0 to +0 and saturate exponents >= 255 to signed infinity.
    function automatic logic [DATA_W-1:0] pack_fp(input logic s,
                                                  input logic signed [10:0] e,
                                                  input logic [22:0] m);
        if (e <= 11'sd0)
            return '0;
        else if (e >= 11'sd255)
            return {s, 8'hFF, 23'h0};
        else
            return {s, e[7:0], m};
    endfunction

    function automatic logic [DATA_W-1:0] fmul(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        logic              s;
        logic [47:0]       p;
        logic signed [10:0] e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00)
            return {s, 31'h0};
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
            return {s, 8'hFF, 23'h0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
        if (p[47])
            return pack_fp(s, e + 11'sd1, p[46:24]);
        else
            return pack_fp(s, e, p[45:23]);
    endfunction

    function automatic logic [DATA_W-1:0] fadd(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0]  big, sml;
        logic [7:0]         d;
        logic [23:0]        mb, ms, diff, norm;
        logic [24:0]        sum;
        logic [4:0]         lz;
        logic               found;
        logic signed [10:0] e;
        logic               a_inf, b_inf;
        a_inf = (a[30:23] == 8'hFF);
        b_inf = (b[30:23] == 8'hFF);
        if (a[30:23] == 8'h00 && b[30:23] == 8'h00)
            return '0;
        // Opposite infinities resolve to +inf rather than NaN.
        if (a_inf && b_inf)
            return (a[31] == b[31]) ? {a[31], 8'hFF, 23'h0} : {1'b0, 8'hFF, 23'h0};
        if (a_inf)
            return {a[31], 8'hFF, 23'h0};
        if (b_inf)
            return {b[31], 8'hFF, 23'h0};
        if (a[30:23] == 8'h00)
            return b;
        if (b[30:23] == 8'h00)
            return a;
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d  = big[30:23] - sml[30:23];
        mb = {1'b1, big[22:0]};
        ms = (d >= 8'd24) ? 24'h0 : ({1'b1, sml[22:0]} >> d);
        e  = $signed({3'b000, big[30:23]});
        if (big[31] == sml[31]) begin
            sum = {1'b0, mb} + {1'b0, ms};
            if (sum[24])
                return pack_fp(big[31], e + 11'sd1, sum[23:1]);
            else
                return pack_fp(big[31], e, sum[22:0]);
        end
        diff = mb - ms;
        if (diff == 24'h0)
            return '0;
        lz    = '0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (diff[i])
                    found = 1'b1;
                else
                    lz = lz + 5'd1;
            end
        end
        norm = diff << lz;
        return pack_fp(big[31], e - $signed({6'b000000, lz}), norm[22:0]);
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MAC;
            MAC:     if (k == K_W'(IN_SIZE - 1)) state_nxt = ACT;
            ACT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = done_q;
    assign in_k = in[DATA_W*int'(k) +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            act_q  <= 1'b0;
            done_q <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == ACT);
            case (state)
                IDLE: if (start) begin
                    k     <= '0;
                    act_q <= activation;
                end
                MAC:  k <= k + K_W'(1);
                ACT: begin
                    for (int o = 0; o < OUT_SIZE; o++)
                        result[DATA_W*o +: DATA_W] <= (act_q && acc[o][31]) ? '0 : acc[o];
                end
                default: ;
            endcase
        end
    end

    // Accumulator stage: bias first, then terms in ascending input order.
    always_ff @(posedge clk) begin
        for (int o = 0; o < OUT_SIZE; o++) begin
            if (state == IDLE && start)
                acc[o] <= bias[DATA_W*o +: DATA_W];
            else if (state == MAC)
                acc[o] <= fadd(acc[o], fmul(in_k, weights[DATA_W*(o*IN_SIZE + int'(k)) +: DATA_W]));
        end
    end

`ifdef NEURAL_LAYER_DISPLAY_EN
    function automatic real fp32_to_real(input logic [DATA_W-1:0] f);
        logic [63:0] dbl;
        if (f[30:23] == 8'h00)
            dbl = {f[31], 63'h0};
        else if (f[30:23] == 8'hFF)
            dbl = {f[31], 11'h7FF, 52'h0};
        else
            dbl = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'h0};
        return $bitstoreal(dbl);
    endfunction

    always @(posedge clk) begin
        if (done_q)
            for (int o = 0; o < OUT_SIZE; o++)
                $display("neuron %0d: %h %e", o, result[DATA_W*o +: DATA_W],
                         fp32_to_real(result[DATA_W*o +: DATA_W]));
    end
`endif

endmodule

// File: tb/tb_neural_layer_par.sv
// Directed bench for neural_layer_par with IN_SIZE=2, OUT_SIZE=2 and hand-computed float32 results.
module tb_neural_layer_par;

    localparam int IN_SIZE  = 2;
    localparam int OUT_SIZE = 2;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            start;
    logic [32*IN_SIZE-1:0]           in_v;
    logic [32*IN_SIZE*OUT_SIZE-1:0]  weights;
    logic [32*OUT_SIZE-1:0]          bias;
    logic                            activation;
    logic [32*OUT_SIZE-1:0]          result;
    logic                            busy;
    logic                            done;

    int total = 0;
    int bad   = 0;

    neural_layer_par #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE)) dut (
        .clk(clk), .rst(rst), .start(start), .in(in_v), .weights(weights),
        .bias(bias), .activation(activation), .result(result), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic set_vec(input logic [31:0] i0, i1, w00, w01, w10, w11, b0, b1);
        in_v    = {i1, i0};
        weights = {w11, w10, w01, w00};
        bias    = {b1, b0};
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (or after the budget).
    task automatic do_eval(input logic act, output int lat, output int busy_cyc);
        int cyc;
        cyc      = 0;
        busy_cyc = 0;
        lat      = -1;
        start      = 1'b1;
        activation = act;
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cyc++;
            if (done) begin
                lat = cyc - 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (result !== 64'h0) begin bad++; $display("FAIL reset_result got=%h exp=%h", result, 64'h0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy=%b done=%b exp 0/0", busy, done); end
    endtask

    task automatic test_basic();
        int lat, bc;
        set_vec(32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3E800000,
                32'hBF800000, 32'hBF800000, 32'h3F800000, 32'h3F000000);
        do_eval(1'b0, lat, bc);
        total++; if (lat !== 3) begin bad++; $display("FAIL basic_latency got=%0d exp=3", lat); end
        total++; if (bc !== 3) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=3", bc); end
        total++; if (result[31:0] !== 32'h40000000) begin bad++; $display("FAIL basic_r0 got=%h exp=40000000", result[31:0]); end
        total++; if (result[63:32] !== 32'hC0200000) begin bad++; $display("FAIL basic_r1 got=%h exp=c0200000", result[63:32]); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b exp=0", done); end
        total++; if (result[63:32] !== 32'hC0200000) begin bad++; $display("FAIL result_hold got=%h exp=c0200000", result[63:32]); end
    endtask

    task automatic test_relu();
        int lat, bc;
        do_eval(1'b1, lat, bc);
        total++; if (result[31:0] !== 32'h40000000) begin bad++; $display("FAIL relu_r0 got=%h exp=40000000", result[31:0]); end
        total++; if (result[63:32] !== 32'h00000000) begin bad++; $display("FAIL relu_r1 got=%h exp=00000000", result[63:32]); end
        @(negedge clk);
    endtask

    task automatic test_zero_inputs();
        int lat, bc;
        set_vec(32'h0, 32'h0, 32'h3F000000, 32'h3E800000,
                32'hBF800000, 32'hBF800000, 32'h3F800000, 32'h3F800000);
        do_eval(1'b1, lat, bc);
        total++; if (result !== {32'h3F800000, 32'h3F800000}) begin bad++; $display("FAIL zero_inputs got=%h exp=3f8000003f800000", result); end
        @(negedge clk);
        in_v = {32'h00000001, 32'h00000001};
        do_eval(1'b1, lat, bc);
        total++; if (result !== {32'h3F800000, 32'h3F800000}) begin bad++; $display("FAIL denormal_inputs got=%h exp=3f8000003f800000", result); end
        @(negedge clk);
    endtask

    task automatic test_saturate();
        int lat, bc;
        set_vec(32'h7F000000, 32'h0, 32'h7F000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        do_eval(1'b0, lat, bc);
        total++; if (result[31:0] !== 32'h7F800000) begin bad++; $display("FAIL saturate_r0 got=%h exp=7f800000", result[31:0]); end
        total++; if (result[63:32] !== 32'h00000000) begin bad++; $display("FAIL saturate_r1 got=%h exp=00000000", result[63:32]); end
        @(negedge clk);
    endtask

    task automatic test_cancel_norm();
        int lat, bc;
        // n0: 1.0 + 1*(-1) -> +0, then + 1.5*0; n1: 0 + 0 + 1.5*1.5 = 2.25
        set_vec(32'h3F800000, 32'h3FC00000, 32'hBF800000, 32'h0,
                32'h0, 32'h3FC00000, 32'h3F800000, 32'h0);
        do_eval(1'b0, lat, bc);
        total++; if (result[31:0] !== 32'h00000000) begin bad++; $display("FAIL cancel_r0 got=%h exp=00000000", result[31:0]); end
        total++; if (result[63:32] !== 32'h40100000) begin bad++; $display("FAIL mulnorm_r1 got=%h exp=40100000", result[63:32]); end
        @(negedge clk);
    endtask

    task automatic test_truncate();
        int lat, bc;
        // n0: 1.0 + 1.5*2^-23 truncates to 1+2^-23; n1: bias -1.0 clamped by ReLU
        set_vec(32'h3F800000, 32'h34400000, 32'h3F800000, 32'h3F800000,
                32'h0, 32'h0, 32'h0, 32'hBF800000);
        do_eval(1'b1, lat, bc);
        total++; if (result[31:0] !== 32'h3F800001) begin bad++; $display("FAIL truncate_r0 got=%h exp=3f800001", result[31:0]); end
        total++; if (result[63:32] !== 32'h00000000) begin bad++; $display("FAIL relu_neg_bias_r1 got=%h exp=00000000", result[63:32]); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat, bc;
        bit seen;
        set_vec(32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3E800000,
                32'hBF800000, 32'hBF800000, 32'h3F800000, 32'h3F000000);
        start      = 1'b1;
        activation = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        total++; if (result !== 64'h0) begin bad++; $display("FAIL abort_result got=%h exp=0", result); end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b exp=0", seen); end
        do_eval(1'b0, lat, bc);
        total++; if (lat !== 3) begin bad++; $display("FAIL restart_latency got=%0d exp=3", lat); end
        total++; if (result !== {32'hC0200000, 32'h40000000}) begin bad++; $display("FAIL restart_result got=%h exp=c020000040000000", result); end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int cyc, dones, lat;
        start      = 1'b1;
        activation = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        cyc   = 0;
        dones = 0;
        lat   = -1;
        while (cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) start = 1'b1;
            if (cyc == 3) start = 1'b0;
            if (done) begin
                dones++;
                if (lat < 0) lat = cyc - 1;
            end
        end
        total++; if (dones !== 1) begin bad++; $display("FAIL busy_start_dones got=%0d exp=1", dones); end
        total++; if (lat !== 3) begin bad++; $display("FAIL busy_start_latency got=%0d exp=3", lat); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_idle got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        do_eval(1'b0, lat, bc);
        total++; if (result[63:32] !== 32'hC0200000) begin bad++; $display("FAIL b2b_first_r1 got=%h exp=c0200000", result[63:32]); end
        do_eval(1'b1, lat, bc);
        total++; if (lat !== 3) begin bad++; $display("FAIL b2b_latency got=%0d exp=3", lat); end
        total++; if (bc !== 3) begin bad++; $display("FAIL b2b_busy_cycles got=%0d exp=3", bc); end
        total++; if (result !== {32'h00000000, 32'h40000000}) begin bad++; $display("FAIL b2b_second got=%h exp=0000000040000000", result); end
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        activation = 1'b0;
        in_v       = '0;
        weights    = '0;
        bias       = '0;
        test_reset();
        test_basic();
        test_relu();
        test_zero_inputs();
        test_saturate();
        test_cancel_norm();
        test_truncate();
        test_reset_abort();
        test_start_while_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
